// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture block.
//   cam_state_e  : capture FSM state encoding (IDLE / WAIT_VS / ACTIVE)
//   FMT_*        : encoding of the fmt input (RGB565 vs xRGB444)
//   pack_pixel() : turns the two camera bytes of one pixel into 12-bit {R,G,B}
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } cam_state_e;

  localparam logic FMT_RGB565 = 1'b0;
  localparam logic FMT_RGB444 = 1'b1;

  localparam int PIX_W = 12;

  // RGB565 keeps the top 4 bits of each channel; xRGB444 already carries
  // 4 bits per channel with the upper nibble of the first byte unused.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic       fmt,
                                                  input logic [7:0] hi,
                                                  input logic [7:0] lo);
    logic [PIX_W-1:0] px;
    if (fmt == FMT_RGB444) px = {hi[3:0], lo[7:4], lo[3:0]};
    else                   px = {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    return px;
  endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchroniser with edge detection for a bundle of asynchronous
// inputs. Every bit goes through the same number of flops, so bits that
// change together at the source (pixel clock and data) stay aligned.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, clears all stages
//   async_i : asynchronous inputs
//   sync_o  : synchronised inputs
//   rise_o  : synchronised bit is high and its previous sample was low
//   fall_o  : synchronised bit is low and its previous sample was high
module cam_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/cam_capture.sv
// OV7670 frame capture into a frame buffer write port.
// The camera signals are oversampled in the system clock domain (clk must be
// at least 4x pclk). Two bytes form one pixel; every DECIM-th pixel of every
// DECIM-th line is written to consecutive frame-buffer addresses.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   pclk, VS, HREF      : raw camera pixel clock, vsync, href (asynchronous)
//   incoming_data       : raw camera data byte
//   enable              : arm capture from the next frame start
//   fmt                 : 0 = RGB565, 1 = xRGB444
//   wr_en/wr_addr/wr_data : frame-buffer write port, wr_data = {R,G,B}
//   frame_done          : one-clk pulse when a captured frame ends
//   overflow            : sticky, a kept pixel was dropped because the buffer was full
//   busy                : FSM is in ACTIVE
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,   // 1, 2 or 4
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pclk,
  input  logic              VS,
  input  logic              HREF,
  input  logic [7:0]        incoming_data,
  input  logic              enable,
  input  logic              fmt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int SYNC_W = 11;
  localparam int XW     = $clog2(H_ACTIVE + 1);
  localparam int YW     = $clog2(V_ACTIVE + 1);

  // Counters saturate at the active size, so anything beyond it is ignored.
  localparam logic [XW-1:0]     X_LIM    = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_LIM    = YW'(V_ACTIVE);
  // DECIM is a power of two, so "x % DECIM == 0" is a mask test.
  localparam logic [XW-1:0]     X_MASK   = XW'(DECIM - 1);
  localparam logic [YW-1:0]     Y_MASK   = YW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic [SYNC_W-1:0] sync_s, rise_s, fall_s;

  cam_sync #(.W(SYNC_W)) u_sync (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .async_i ({pclk, VS, HREF, incoming_data}),
    .sync_o  (sync_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  logic       pclk_rise, vs_rise, vs_fall, href_s, href_fall;
  logic [7:0] data_s;

  assign pclk_rise = rise_s[10];
  assign vs_rise   = rise_s[9];
  assign vs_fall   = fall_s[9];
  assign href_s    = sync_s[8];
  assign href_fall = fall_s[8];
  assign data_s    = sync_s[7:0];

  // Edges of the remaining bits are not needed.
  logic unused_edges;
  assign unused_edges = ^{rise_s[8:0], fall_s[10], fall_s[7:0], sync_s[10:9]};

  cam_state_e        state_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              full_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic              frame_done_q;
  logic              overflow_q;

  logic pix_keep_d;
  assign pix_keep_d = (x_q < X_LIM) && (y_q < Y_LIM) &&
                      ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      full_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      // The address advances in the cycle after each write; the last address
      // is kept and marks the buffer full instead of wrapping.
      if (wr_en_q) begin
        if (wr_addr_q == ADDR_MAX) full_q    <= 1'b1;
        else                       wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_WAIT_VS;
        end

        ST_WAIT_VS: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (vs_fall) begin
            state_q    <= ST_ACTIVE;
            phase_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            wr_addr_q  <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (pclk_rise && href_s) begin
            if (!phase_q) begin
              hi_q    <= data_s;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (x_q != X_LIM) x_q <= x_q + XW'(1);
              if (pix_keep_d) begin
                if (full_q) begin
                  overflow_q <= 1'b1;
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= pack_pixel(fmt, hi_q, data_s);
                end
              end
            end
          end else if (href_fall) begin
            // A byte left over from an odd-length line is dropped here.
            phase_q <= 1'b0;
            x_q     <= '0;
            if (y_q != Y_LIM) y_q <= y_q + YW'(1);
          end

          // A pixel completed in this same cycle is still written above.
          if (vs_rise) begin
            frame_done_q <= 1'b1;
            state_q      <= enable ? ST_WAIT_VS : ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: two instances (DECIM=1/ADDR_W=3 and DECIM=2/ADDR_W=5)
// share one simulated camera. A frame-level model predicts the write stream,
// frame_done count and overflow for each instance.
module tb_cam_capture;

  localparam int H = 8;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pclk = 1'b0;
  logic       VS = 1'b1;
  logic       HREF = 1'b0;
  logic       enable = 1'b0;
  logic       fmt = 1'b0;
  logic [7:0] incoming_data = 8'h00;

  logic        wr_en_a, frame_done_a, overflow_a, busy_a;
  logic [2:0]  wr_addr_a;
  logic [11:0] wr_data_a;
  logic        wr_en_b, frame_done_b, overflow_b, busy_b;
  logic [4:0]  wr_addr_b;
  logic [11:0] wr_data_b;

  always #5 clk = ~clk;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .VS(VS), .HREF(HREF),
    .incoming_data(incoming_data), .enable(enable), .fmt(fmt),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .frame_done(frame_done_a), .overflow(overflow_a), .busy(busy_a)
  );

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .VS(VS), .HREF(HREF),
    .incoming_data(incoming_data), .enable(enable), .fmt(fmt),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .frame_done(frame_done_b), .overflow(overflow_b), .busy(busy_b)
  );

  // Counters of the stimulus process and of the compare process.
  int n_checks = 0, n_pass = 0;
  int c_checks = 0, c_pass = 0;

  // Frame content: fb[line][byte], flen[line] bytes per line.
  logic [7:0] fb [8][32];
  int         flen [8];

  // Expected write streams (filled by the model, consumed by the compare process).
  int          exp_a_addr [256];
  logic [11:0] exp_a_data [256];
  int          exp_n_a = 0;
  int          exp_b_addr [256];
  logic [11:0] exp_b_data [256];
  int          exp_n_b = 0;
  bit          mdl_ovf_a = 1'b0, mdl_ovf_b = 1'b0;

  // Observations made by the compare process.
  int rd_a = 0, rd_b = 0;
  int wr_cnt_a = 0, wr_cnt_b = 0;
  int fd_cnt_a = 0, fd_cnt_b = 0;
  int last_addr_a = -1, last_addr_b = -1;
  int last_data_a = -1, last_data_b = -1;

  always @(negedge clk) begin
    if (wr_en_a) begin
      wr_cnt_a++;
      last_addr_a = int'(wr_addr_a);
      last_data_a = int'(wr_data_a);
      c_checks++;
      if (rd_a >= exp_n_a)
        $display("FAIL write_a: unexpected write addr %0d data 0x%03h, required none", wr_addr_a, wr_data_a);
      else if (int'(wr_addr_a) == exp_a_addr[rd_a] && wr_data_a == exp_a_data[rd_a])
        c_pass++;
      else
        $display("FAIL write_a: actual addr %0d data 0x%03h, required addr %0d data 0x%03h",
                 wr_addr_a, wr_data_a, exp_a_addr[rd_a], exp_a_data[rd_a]);
      rd_a++;
    end
    if (wr_en_b) begin
      wr_cnt_b++;
      last_addr_b = int'(wr_addr_b);
      last_data_b = int'(wr_data_b);
      c_checks++;
      if (rd_b >= exp_n_b)
        $display("FAIL write_b: unexpected write addr %0d data 0x%03h, required none", wr_addr_b, wr_data_b);
      else if (int'(wr_addr_b) == exp_b_addr[rd_b] && wr_data_b == exp_b_data[rd_b])
        c_pass++;
      else
        $display("FAIL write_b: actual addr %0d data 0x%03h, required addr %0d data 0x%03h",
                 wr_addr_b, wr_data_b, exp_b_addr[rd_b], exp_b_data[rd_b]);
      rd_b++;
    end
    if (frame_done_a) fd_cnt_a++;
    if (frame_done_b) fd_cnt_b++;
  end

  task automatic t_chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Colour conversion from the byte pair, in plain arithmetic.
  function automatic logic [11:0] px(input bit fm, input int hi, input int lo);
    int r, g, b;
    if (!fm) begin
      r = hi / 16;
      g = (hi % 8) * 2 + lo / 128;
      b = (lo / 2) % 16;
    end else begin
      r = hi % 16;
      g = lo / 16;
      b = lo % 16;
    end
    return 12'(r * 256 + g * 16 + b);
  endfunction

  // Predict the writes of one captured frame for instance a (0) or b (1).
  task automatic model_frame(input bit which_b, input bit cap, input int nl);
    int d, aw, addr, hi, lo;
    bit full, ovf;
    if (!cap) return;
    d    = which_b ? 2 : 1;
    aw   = which_b ? 5 : 3;
    addr = 0;
    full = 1'b0;
    ovf  = 1'b0;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < flen[l] / 2; p++) begin
        if (p < H && l < V && p % d == 0 && l % d == 0) begin
          if (full) begin
            ovf = 1'b1;
          end else begin
            hi = int'(fb[l][2*p]);
            lo = int'(fb[l][2*p+1]);
            if (which_b) begin
              exp_b_addr[exp_n_b] = addr;
              exp_b_data[exp_n_b] = px(fmt, hi, lo);
              exp_n_b++;
            end else begin
              exp_a_addr[exp_n_a] = addr;
              exp_a_data[exp_n_a] = px(fmt, hi, lo);
              exp_n_a++;
            end
            if (addr == (1 << aw) - 1) full = 1'b1;
            else addr++;
          end
        end
      end
    end
    if (which_b) mdl_ovf_b = ovf;
    else         mdl_ovf_a = ovf;
  endtask

  task automatic pclk_tick();
    #40 pclk = 1'b1;
    #40 pclk = 1'b0;
  endtask

  task automatic fill_lines(input int nl, input int len, input int seed);
    for (int l = 0; l < nl; l++) begin
      flen[l] = len;
      for (int b = 0; b < len; b++) fb[l][b] = 8'((seed + l * 37 + b * 11) % 256);
    end
  endtask

  // One camera frame: VS low for the frame, HREF high per line.
  task automatic send_frame(input string tag, input int nl, input bit cap,
                            input int drop_line, input bit rst_mid);
    int  fd0_a, fd0_b;
    bit  ovf_prev_a;
    ovf_prev_a = mdl_ovf_a;
    model_frame(1'b0, cap, nl);
    model_frame(1'b1, cap, nl);
    fd0_a = fd_cnt_a;
    fd0_b = fd_cnt_b;
    VS = 1'b0;
    repeat (3) pclk_tick();
    if (rst_mid) begin
      rst_n = 1'b0;
      #30 rst_n = 1'b1;
      mdl_ovf_a = 1'b0;
      mdl_ovf_b = 1'b0;
      ovf_prev_a = 1'b0;
      repeat (2) pclk_tick();
    end
    t_chk({tag, " busy_a"}, int'(busy_a), int'(cap));
    t_chk({tag, " busy_b"}, int'(busy_b), int'(cap));
    t_chk({tag, " overflow_a at start"}, int'(overflow_a), cap ? 0 : int'(ovf_prev_a));
    for (int l = 0; l < nl; l++) begin
      if (l == drop_line) enable = 1'b0;
      HREF = 1'b1;
      for (int b = 0; b < flen[l]; b++) begin
        incoming_data = fb[l][b];
        pclk_tick();
      end
      HREF = 1'b0;
      incoming_data = 8'h00;
      repeat (3) pclk_tick();
    end
    VS = 1'b1;
    repeat (4) pclk_tick();
    t_chk({tag, " writes_a seen"}, rd_a, exp_n_a);
    t_chk({tag, " writes_b seen"}, rd_b, exp_n_b);
    t_chk({tag, " frame_done_a pulses"}, fd_cnt_a - fd0_a, int'(cap));
    t_chk({tag, " frame_done_b pulses"}, fd_cnt_b - fd0_b, int'(cap));
    t_chk({tag, " overflow_a"}, int'(overflow_a), int'(mdl_ovf_a));
    t_chk({tag, " overflow_b"}, int'(overflow_b), int'(mdl_ovf_b));
    t_chk({tag, " busy_a after"}, int'(busy_a), 0);
    t_chk({tag, " busy_b after"}, int'(busy_b), 0);
  endtask

  int wa0, wb0;

  initial begin
    // Reset state.
    #40;
    t_chk("rst wr_en_a", int'(wr_en_a), 0);
    t_chk("rst wr_addr_a", int'(wr_addr_a), 0);
    t_chk("rst wr_data_a", int'(wr_data_a), 0);
    t_chk("rst frame_done_a", int'(frame_done_a), 0);
    t_chk("rst overflow_a", int'(overflow_a), 0);
    t_chk("rst busy_a", int'(busy_a), 0);
    t_chk("rst outputs_b", int'({wr_en_b, wr_addr_b, wr_data_b, frame_done_b, overflow_b, busy_b}), 0);
    rst_n = 1'b1;
    #40 enable = 1'b1;
    #200;

    // RGB565 pixel F8,00 -> F00 at address 0.
    fmt = 1'b0;
    flen[0] = 2; fb[0][0] = 8'hF8; fb[0][1] = 8'h00;
    send_frame("f1", 1, 1'b1, -1, 1'b0);
    t_chk("f1 data_a literal", last_data_a, 12'hF00);
    t_chk("f1 addr_a literal", last_addr_a, 0);
    t_chk("f1 data_b literal", last_data_b, 12'hF00);

    // xRGB444 pixel 0A,5C -> A5C, address restarts at 0.
    fmt = 1'b1;
    flen[0] = 2; fb[0][0] = 8'h0A; fb[0][1] = 8'h5C;
    send_frame("f2", 1, 1'b1, -1, 1'b0);
    t_chk("f2 data_a literal", last_data_a, 12'hA5C);
    t_chk("f2 addr_a literal", last_addr_a, 0);

    // 8x4 frame: DECIM=2 gives 8 writes at 0..7; ADDR_W=3 overflows.
    fmt = 1'b0;
    fill_lines(4, 16, 3);
    wa0 = wr_cnt_a; wb0 = wr_cnt_b;
    send_frame("f3", 4, 1'b1, -1, 1'b0);
    t_chk("f3 writes_b literal", wr_cnt_b - wb0, 8);
    t_chk("f3 last addr_b literal", last_addr_b, 7);
    t_chk("f3 writes_a literal", wr_cnt_a - wa0, 8);
    t_chk("f3 overflow_a literal", int'(overflow_a), 1);

    // 16 pixels into an 8-entry buffer.
    fill_lines(2, 16, 90);
    wa0 = wr_cnt_a;
    send_frame("f4", 2, 1'b1, -1, 1'b0);
    t_chk("f4 writes_a literal", wr_cnt_a - wa0, 8);
    t_chk("f4 last addr_a literal", last_addr_a, 7);
    t_chk("f4 overflow_a literal", int'(overflow_a), 1);

    // Odd-length line: byte 56 is dropped, next line starts with 9A as hi.
    flen[0] = 3; fb[0][0] = 8'h12; fb[0][1] = 8'h34; fb[0][2] = 8'h56;
    flen[1] = 2; fb[1][0] = 8'h9A; fb[1][1] = 8'hBC;
    wa0 = wr_cnt_a; wb0 = wr_cnt_b;
    send_frame("f5", 2, 1'b1, -1, 1'b0);
    t_chk("f5 writes_a literal", wr_cnt_a - wa0, 2);
    t_chk("f5 data_a literal", last_data_a, 12'h95E);
    t_chk("f5 writes_b literal", wr_cnt_b - wb0, 1);
    t_chk("f5 overflow_a cleared", int'(overflow_a), 0);

    // Enable dropped mid-frame: frame still completes, then IDLE.
    fill_lines(2, 4, 7);
    wa0 = wr_cnt_a;
    send_frame("f6", 2, 1'b1, 1, 1'b0);
    t_chk("f6 writes_a literal", wr_cnt_a - wa0, 4);

    // Following frame with enable low produces nothing.
    fill_lines(1, 4, 21);
    wa0 = wr_cnt_a; wb0 = wr_cnt_b;
    send_frame("f7", 1, 1'b0, -1, 1'b0);
    t_chk("f7 writes_a literal", wr_cnt_a - wa0, 0);
    t_chk("f7 writes_b literal", wr_cnt_b - wb0, 0);

    // Re-arm, then reset in the middle of a frame: rest of it is ignored.
    enable = 1'b1;
    #200;
    fill_lines(3, 4, 55);
    wa0 = wr_cnt_a;
    send_frame("f8", 3, 1'b0, -1, 1'b1);
    t_chk("f8 writes_a literal", wr_cnt_a - wa0, 0);

    // Line longer than H_ACTIVE: pixels beyond it are ignored, not overflow.
    fmt = 1'b1;
    fill_lines(1, 20, 13);
    wa0 = wr_cnt_a; wb0 = wr_cnt_b;
    send_frame("f9", 1, 1'b1, -1, 1'b0);
    t_chk("f9 writes_a literal", wr_cnt_a - wa0, 8);
    t_chk("f9 writes_b literal", wr_cnt_b - wb0, 4);
    t_chk("f9 overflow_a literal", int'(overflow_a), 0);

    // More lines than V_ACTIVE: extra lines are ignored.
    fmt = 1'b0;
    fill_lines(6, 2, 77);
    wa0 = wr_cnt_a; wb0 = wr_cnt_b;
    send_frame("f10", 6, 1'b1, -1, 1'b0);
    t_chk("f10 writes_a literal", wr_cnt_a - wa0, 4);
    t_chk("f10 writes_b literal", wr_cnt_b - wb0, 2);

    #100;
    $display("%0d/%0d checks passed", n_pass + c_pass, n_checks + c_checks);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning pixels per camera line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning lines per camera frame.
REQ-003 SHALL have parameter DECIM, default 1, meaning legal values 1/2/4; keep every DECIM-th pixel and line.
REQ-004 SHALL have parameter ADDR_W, default 19, meaning frame-buffer address width.
REQ-005 SHALL have port clk, input, 1 bit, meaning system clock; the block's only clock, frequency at least 4x pclk.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have ports pclk, VS, HREF, input, 1 bit each, meaning raw OV7670 pixel clock, vsync and href, all asynchronous to clk.
REQ-008 SHALL have port incoming_data, input, 8 bits, meaning raw OV7670 data byte.
REQ-009 SHALL have port enable, input, 1 bit, meaning arm capture from the next frame start.
REQ-010 SHALL have port fmt, input, 1 bit, meaning 0 = RGB565, 1 = RGB444 (xRGB).
REQ-011 SHALL have ports wr_en (1), wr_addr (ADDR_W) and wr_data (12, {R,G,B}), all outputs, meaning frame-buffer write port.
REQ-012 SHALL have port frame_done, output, 1 bit, meaning one-clk pulse at the end of a captured frame.
REQ-013 SHALL have port overflow, output, 1 bit, meaning sticky: a write was suppressed because the buffer was full.
REQ-014 SHALL have port busy, output, 1 bit, meaning the state machine is in ACTIVE.

Function
REQ-015 SHALL pass pclk, VS, HREF and incoming_data through an identical 2-flop synchroniser; a pclk rising edge is synced pclk high while its previous sample was low.
REQ-016 SHALL sample the byte only on a detected pclk edge with synced HREF high.
REQ-017 SHALL use a byte-phase toggle: first byte latched as hi, second byte completes a pixel; the phase is cleared when HREF falls and at frame start.
REQ-018 SHALL, for fmt=0, form R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1]; for fmt=1, R=hi[3:0], G=lo[7:4], B=lo[3:0].
REQ-019 SHALL count pixel x (0..H_ACTIVE-1, cleared on HREF fall) and line y (incremented on HREF fall, cleared at frame start); a pixel is kept iff x%DECIM==0 and y%DECIM==0.
REQ-020 SHALL assert wr_en for exactly one clk, on the clk after the edge that completed a kept pixel, with wr_data and wr_addr valid in that same cycle.
REQ-021 SHALL start wr_addr at 0 on each frame start and increment it by 1 after every write.
REQ-022 SHALL suppress writes once wr_addr == 2^ADDR_W-1 has been written, and set overflow; wr_addr then holds.
REQ-023 SHALL implement FSM IDLE -> WAIT_VS (enable=1) -> ACTIVE (synced VS falling edge = frame start) -> WAIT_VS on synced VS rising edge, pulsing frame_done on that transition.
REQ-024 SHALL, on leaving ACTIVE, go to IDLE instead of WAIT_VS if enable is 0; deasserting enable mid-frame SHALL NOT truncate the current frame.
REQ-025 SHALL ignore pixels outside ACTIVE and pixels with x>=H_ACTIVE or y>=V_ACTIVE.
REQ-026 SHALL clear overflow at each frame start.
REQ-027 SHALL treat a VS rise and a completed pixel in the same clk as: write the pixel, then end the frame.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, synchronisers 0, wr_en 0, wr_addr 0, wr_data 0, frame_done 0, overflow 0, busy 0, and the counters and phase to 0.
REQ-029 SHALL, after reset is released mid-frame, ignore bytes until the next full VS cycle.

Structure
REQ-030 SHALL place the FSM state encoding and the fmt encoding constants in the shared package cam_pkg.
REQ-031 SHALL implement the synchroniser plus edge detector as sub-module cam_sync (parametrised width), instantiated once for {pclk,VS,HREF,data}.

Verification
REQ-032 SHALL include scenario: fmt=0, DECIM=1, bytes 0xF8,0x00 -> wr_data=0xF00, wr_addr=0.
REQ-033 SHALL include scenario: fmt=1, bytes 0x0A,0x5C -> wr_data=0xA5C.
REQ-034 SHALL include scenario: DECIM=2, 8x4 frame -> exactly 8 writes, addresses 0..7, then one frame_done.
REQ-035 SHALL include scenario: ADDR_W=3, 16 pixels -> 8 writes, overflow=1, cleared at the next VS fall.
REQ-036 SHALL include scenario: enable dropped mid-frame -> the frame completes, frame_done pulses, FSM goes to IDLE, and later frames give no writes.
REQ-037 SHALL include scenario: HREF falls after an odd byte -> the dangling byte is discarded and the next line starts on the hi byte.
